seq_checker: RTL and testbench

SEQ_CHECKER -- requirements
Module: seq_checker

---
 rtl/seq_checker.sv | 113 +++++++++++
 tb/tb_seq_checker.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_checker.sv
// Checks a player's button presses against a sequence ROM, one step per press.
// Optional per-press timeout is enabled by defining SEQ_CHECKER_TIMEOUT_EN.
module seq_checker #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [3:0] nivel,
  input  logic [3:0] botoes,
  output logic [3:0] address,
  input  logic [3:0] seq_in,
  output logic       ocupado,
  output logic       acerto,
  output logic       erro
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_REL,
    WAIT_PRESS,
    OK,
    FAIL
  } state_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("seq_checker: TIMEOUT_CYCLES must be in 1..65535");
  end

  state_t     state_q, state_d;
  logic [3:0] address_q, address_d;
  logic [3:0] nivel_q, nivel_d;

`ifdef SEQ_CHECKER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] timer_q, timer_d;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      address_q <= 4'd0;
      nivel_q   <= 4'd0;
`ifdef SEQ_CHECKER_TIMEOUT_EN
      timer_q   <= 16'd0;
`endif
    end else begin
      state_q   <= state_d;
      address_q <= address_d;
      nivel_q   <= nivel_d;
`ifdef SEQ_CHECKER_TIMEOUT_EN
      timer_q   <= timer_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    address_d = address_q;
    nivel_d   = nivel_q;
`ifdef SEQ_CHECKER_TIMEOUT_EN
    timer_d   = timer_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          nivel_d   = nivel;
          address_d = 4'd0;
          state_d   = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (botoes == 4'b0000) begin
          state_d = WAIT_PRESS;
`ifdef SEQ_CHECKER_TIMEOUT_EN
          timer_d = 16'd0;
`endif
        end
      end
      WAIT_PRESS: begin
        // A press always wins over an expiring timeout in the same cycle
        if (botoes != 4'b0000) begin
          if (botoes == seq_in) begin
            if (address_q == nivel_q) begin
              state_d = OK;
            end else begin
              address_d = address_q + 4'd1;
              state_d   = WAIT_REL;
            end
          end else begin
            state_d = FAIL;
          end
        end
`ifdef SEQ_CHECKER_TIMEOUT_EN
        else if (timer_q == TIMEOUT_LAST) begin
          state_d = FAIL;
        end else begin
          timer_d = timer_q + 16'd1;
        end
`endif
      end
      OK:      state_d = IDLE;
      FAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign address = address_q;
  assign ocupado = (state_q != IDLE);
  assign acerto  = (state_q == OK);
  assign erro    = (state_q == FAIL);

endmodule

// File: tb/tb_seq_checker.sv
// Directed bench for seq_checker with a small combinational ROM model.
// Define SEQ_CHECKER_TIMEOUT_EN to exercise the timeout build (TIMEOUT_CYCLES=8).
`timescale 1ns/1ps
module tb_seq_checker;

  logic       clock;
  logic       reset_n;
  logic       start;
  logic [3:0] nivel;
  logic [3:0] botoes;
  logic [3:0] address;
  logic [3:0] seq_in;
  logic       ocupado;
  logic       acerto;
  logic       erro;

  int checks;
  int failures;
  int acerto_cnt;
  int erro_cnt;
  int both_cnt;

`ifdef SEQ_CHECKER_TIMEOUT_EN
  seq_checker #(.TIMEOUT_CYCLES(8)) dut (
`else
  seq_checker dut (
`endif
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .nivel   (nivel),
    .botoes  (botoes),
    .address (address),
    .seq_in  (seq_in),
    .ocupado (ocupado),
    .acerto  (acerto),
    .erro    (erro)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [3:0] rom(input logic [3:0] a);
    logic [3:0] one;
    one = 4'b0001;
    case (a)
      4'd0:    rom = 4'b0001;
      4'd1:    rom = 4'b0100;
      4'd2:    rom = 4'b0010;
      default: rom = one << a[1:0];
    endcase
  endfunction

  assign seq_in = rom(address);

  // Pulse counters observed away from the active edge
  always @(negedge clock) begin
    if (acerto === 1'b1) acerto_cnt++;
    if (erro === 1'b1) erro_cnt++;
    if (acerto === 1'b1 && erro === 1'b1) both_cnt++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    botoes  = 4'b0000;
    nivel   = 4'd0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic start_round(input logic [3:0] n);
    nivel = n;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic press_release(input logic [3:0] b);
    botoes = b;
    tick();
    botoes = 4'b0000;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    botoes  = 4'b0000;
    nivel   = 4'd0;
    tick();
    tick();
    checks++;
    if ({ocupado, acerto, erro, address} !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs: got ocupado=%b acerto=%b erro=%b address=%0d, expected all 0",
               ocupado, acerto, erro, address);
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if (ocupado !== 1'b0 || address !== 4'd0) begin
      failures++;
      $display("FAIL reset_idle: got ocupado=%b address=%0d, expected 0/0", ocupado, address);
    end
  endtask

  task automatic test_correct_round();
    int a0, e0;
    a0 = acerto_cnt;
    e0 = erro_cnt;
    start_round(4'd2);
    nivel = 4'd9;
    checks++;
    if (ocupado !== 1'b1 || address !== 4'd0) begin
      failures++;
      $display("FAIL correct_busy: got ocupado=%b address=%0d, expected 1/0", ocupado, address);
    end
    press_release(4'b0001);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (address !== 4'd1 || ocupado !== 1'b1) begin
      failures++;
      $display("FAIL start_ignored: got address=%0d ocupado=%b, expected 1/1", address, ocupado);
    end
    press_release(4'b0100);
    botoes = 4'b0010;
    tick();
    checks++;
    if (acerto !== 1'b1 || erro !== 1'b0 || address !== 4'd2) begin
      failures++;
      $display("FAIL correct_ok: got acerto=%b erro=%b address=%0d, expected 1/0/2", acerto, erro, address);
    end
    botoes = 4'b0000;
    tick();
    checks++;
    if (acerto !== 1'b0 || ocupado !== 1'b0 || address !== 4'd2) begin
      failures++;
      $display("FAIL correct_after: got acerto=%b ocupado=%b address=%0d, expected 0/0/2", acerto, ocupado, address);
    end
    checks++;
    if (acerto_cnt - a0 !== 1 || erro_cnt - e0 !== 0) begin
      failures++;
      $display("FAIL correct_pulses: got acerto=%0d erro=%0d pulses, expected 1/0", acerto_cnt - a0, erro_cnt - e0);
    end
  endtask

  task automatic test_wrong_color();
    start_round(4'd2);
    press_release(4'b0001);
    botoes = 4'b0010;
    tick();
    checks++;
    if (erro !== 1'b1 || acerto !== 1'b0 || address !== 4'd1) begin
      failures++;
      $display("FAIL wrong_erro: got erro=%b acerto=%b address=%0d, expected 1/0/1", erro, acerto, address);
    end
    botoes = 4'b0000;
    tick();
    checks++;
    if (ocupado !== 1'b0 || erro !== 1'b0 || address !== 4'd1) begin
      failures++;
      $display("FAIL wrong_after: got ocupado=%b erro=%b address=%0d, expected 0/0/1", ocupado, erro, address);
    end
  endtask

  task automatic test_multi_button();
    start_round(4'd2);
    botoes = 4'b0101;
    tick();
    checks++;
    if (erro !== 1'b1 || acerto !== 1'b0 || address !== 4'd0) begin
      failures++;
      $display("FAIL multi_erro: got erro=%b acerto=%b address=%0d, expected 1/0/0", erro, acerto, address);
    end
    botoes = 4'b0000;
    tick();
  endtask

  task automatic test_hold_button();
    int a0;
    a0 = acerto_cnt;
    botoes = 4'b0001;
    nivel  = 4'd0;
    start  = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (ocupado !== 1'b1 || acerto !== 1'b0 || erro !== 1'b0 || address !== 4'd0 || acerto_cnt !== a0) begin
      failures++;
      $display("FAIL hold_noprogress: got ocupado=%b acerto=%b erro=%b address=%0d, expected 1/0/0/0",
               ocupado, acerto, erro, address);
    end
    botoes = 4'b0000;
    tick();
    botoes = 4'b0001;
    tick();
    checks++;
    if (acerto !== 1'b1 || erro !== 1'b0) begin
      failures++;
      $display("FAIL hold_accept: got acerto=%b erro=%b, expected 1/0", acerto, erro);
    end
    botoes = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid_round();
    int a0, e0;
    start_round(4'd2);
    press_release(4'b0001);
    a0 = acerto_cnt;
    e0 = erro_cnt;
    reset_n = 1'b0;
    tick();
    checks++;
    if ({ocupado, acerto, erro, address} !== 7'b0) begin
      failures++;
      $display("FAIL midreset_outputs: got ocupado=%b acerto=%b erro=%b address=%0d, expected all 0",
               ocupado, acerto, erro, address);
    end
    reset_n = 1'b1;
    nivel   = 4'd1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (ocupado !== 1'b1 || address !== 4'd0) begin
      failures++;
      $display("FAIL midreset_restart: got ocupado=%b address=%0d, expected 1/0", ocupado, address);
    end
    checks++;
    if (acerto_cnt !== a0 || erro_cnt !== e0) begin
      failures++;
      $display("FAIL midreset_pulses: got %0d acerto %0d erro pulses, expected 0/0", acerto_cnt - a0, erro_cnt - e0);
    end
    tick();
    press_release(4'b0001);
    botoes = 4'b0100;
    tick();
    checks++;
    if (acerto !== 1'b1 || address !== 4'd1) begin
      failures++;
      $display("FAIL midreset_complete: got acerto=%b address=%0d, expected 1/1", acerto, address);
    end
    botoes = 4'b0000;
    tick();
  endtask

  task automatic test_max_level();
    start_round(4'd15);
    for (int i = 0; i < 15; i++) begin
      press_release(rom(4'(i)));
    end
    checks++;
    if (address !== 4'd15 || ocupado !== 1'b1) begin
      failures++;
      $display("FAIL max_last_addr: got address=%0d ocupado=%b, expected 15/1", address, ocupado);
    end
    botoes = 4'b1000;
    tick();
    checks++;
    if (acerto !== 1'b1 || address !== 4'd15) begin
      failures++;
      $display("FAIL max_ok: got acerto=%b address=%0d, expected 1/15", acerto, address);
    end
    botoes = 4'b0000;
    tick();
    checks++;
    if (address !== 4'd15 || ocupado !== 1'b0) begin
      failures++;
      $display("FAIL max_nowrap: got address=%0d ocupado=%b, expected 15/0", address, ocupado);
    end
  endtask

  task automatic test_timeout();
`ifdef SEQ_CHECKER_TIMEOUT_EN
    int early;
    early = 0;
    start_round(4'd2);
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (erro === 1'b1) early++;
    end
    checks++;
    if (early !== 0) begin
      failures++;
      $display("FAIL timeout_early: got %0d early erro cycles, expected 0", early);
    end
    tick();
    checks++;
    if (erro !== 1'b1 || acerto !== 1'b0) begin
      failures++;
      $display("FAIL timeout_erro: got erro=%b acerto=%b, expected 1/0", erro, acerto);
    end
    tick();
`else
    int e0;
    e0 = erro_cnt;
    start_round(4'd2);
    repeat (1000) tick();
    checks++;
    if (erro_cnt !== e0 || ocupado !== 1'b1 || address !== 4'd0) begin
      failures++;
      $display("FAIL no_timeout: got %0d erro pulses ocupado=%b address=%0d, expected 0/1/0",
               erro_cnt - e0, ocupado, address);
    end
    do_reset();
`endif
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    acerto_cnt = 0;
    erro_cnt   = 0;
    both_cnt   = 0;
    reset_n    = 1'b0;
    start      = 1'b0;
    nivel      = 4'd0;
    botoes     = 4'b0000;
    test_reset();
    test_correct_round();
    test_wrong_color();
    test_multi_button();
    test_hold_button();
    test_reset_mid_round();
    test_max_level();
    test_timeout();
    checks++;
    if (both_cnt !== 0) begin
      failures++;
      $display("FAIL exclusive_pulses: got %0d cycles with acerto and erro together, expected 0", both_cnt);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
